cpu_cycle_sequencer: RTL
========================

// Module: cpu_cycle_sequencer
// PURPOSE
// - Sequences every CPU instruction through its 5/7/12-clock budget (instr_length).
//   Sits between the opcode fetch/decoder and the microcode/ALU datapath.
// - Issues the opcode fetch strobe, the micro-op slot index and the microcode_cycle phase.
// - Schedules interrupt entry and HALT at instruction boundaries.
// PARAMETERS
// - FETCH_STEPS  2   leading steps of every instruction used for fetch/decode (slot-free)
// - INT_LENGTH   12  clock-enabled steps consumed by interrupt entry sequence
// - STEP_W       4   width of step counter (must hold max(12, INT_LENGTH)-1)
// PORTS
// - clk            in   1  system clock
// - reset_n        in   1  synchronous active-low reset
// - clk_en         in   1  CPU-rate enable; all state advances only when high
// - length         in   2  instr_length from decoder: 0=CYCLE5, 1=CYCLE7, 2=CYCLE12, 3=illegal
// - halt_req       in   1  decoder flags current instr as HALT/SLP (sampled at step 1)
// - irq_pending    in   1  any unmasked interrupt factor pending
// - int_enable     in   1  CPU I flag
// - fetch_strobe   out  1  high during step 0 of a normal instruction (ROM read)
// - decode_strobe  out  1  high during step 1 (length/halt_req latched)
// - step           out  STEP_W  current step within instruction
// - uop_index      out  3  micro-op slot number = (step-FETCH_STEPS)>>1
// - uop_phase      out  2  microcode_cycle: 0 NONE, 1 REG_FETCH, 2 REG_WRITE
// - instr_done     out  1  high on last step of instruction or interrupt entry
// - int_active     out  1  high throughout interrupt entry sequence
// - halted         out  1  high while in HALT
// - illegal_len    out  1  sticky; set when length==3 latched, cleared by reset only
// BEHAVIOUR
// - Reset (reset_n low at clk edge): state=RUN, step=0, all outputs 0 except
//   fetch_strobe=1 once clk_en seen. Reset wins over every other input, mid-instruction too.
// - States: RUN, INT_ENTRY, HALT. Step counter increments only when clk_en=1; outputs are
//   decoded from registered state/step (no combinational path from inputs).
// - Length latched at step 1 (decode_strobe & clk_en). N = 5/7/12; length==3 -> N=5, illegal_len<=1.
// - Steps 0..FETCH_STEPS-1: uop_phase=NONE. Steps s>=FETCH_STEPS: k=s-FETCH_STEPS;
//   phase=REG_FETCH if k even, REG_WRITE if k odd; an unpaired final step is NONE.
//   CYCLE5: slot0 at 2,3; step4 NONE. CYCLE7: slots0-1; step6 NONE. CYCLE12: slots0-4.
// - instr_done high on step N-1; on the following clk_en the boundary decision is taken:
//   1. halt latched -> HALT (step=0, halted=1)
//   2. else irq_pending & int_enable -> INT_ENTRY
//   3. else RUN with step=0 (fetch).
//   Priority: halt > interrupt > next fetch.
// - INT_ENTRY: int_active=1, fetch_strobe/decode_strobe=0, length forced INT_LENGTH; slot/phase
//   decode identical to RUN. On step INT_LENGTH-1, instr_done=1, then -> RUN step 0.
//   Interrupts are never nested: irq_pending ignored inside INT_ENTRY.
// - HALT: step held 0, all strobes 0, uop_phase NONE. Exit on irq_pending=1 (regardless of
//   int_enable) at a clk_en cycle: if int_enable -> INT_ENTRY, else RUN step 0.
// - clk_en low: every register holds; outputs stable. halt_req/length ignored outside step 1.
// - Step counter never wraps past N-1; no state beyond step 11 reachable.
// CONFIGURATION
// - SEQ_SINGLE_STEP_EN: adds inputs dbg_hold (1) and dbg_step (1, pulse).
//   Defined: at every RUN boundary the sequencer holds step 0 with fetch_strobe=0 while
//   dbg_hold=1, until a dbg_step pulse coincident with clk_en releases exactly one
//   instruction. INT_ENTRY and HALT exit behave unchanged.
//   Undefined: ports absent, boundaries never stall.
// TESTING
// - Reset then clk_en every clock, length=0 -> fetch_strobe at steps 0,5,10; instr_done at 4,9;
//   uop_phase 0,0,1,2,0 per instr.
// - length=2, clk_en every 3rd clock -> 12 enabled steps; uop_index 0..4 with phases
//   alternating 1/2; all outputs frozen on disabled clocks.
// - irq_pending=1, int_enable=1 raised at step 3 of a CYCLE7 instr -> instruction finishes
//   (instr_done step 6), then int_active=1 for 12 steps, then fetch_strobe.
// - halt_req=1 at step 1 with irq_pending=1 -> HALT entered anyway. Hold irq_pending=1,
//   int_enable=0 -> halted for 1 step then RUN fetch, no int_active.
// - length=3 -> 5-step instruction, illegal_len=1 persists; reset_n=0 at step 2 of next instr ->
//   step=0, illegal_len=0.
// - SEQ_SINGLE_STEP_EN: dbg_hold=1 -> no fetch for 20 clocks; one dbg_step -> exactly one
//   fetch_strobe, next boundary stalls.

Source files
------------

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: walks each CPU instruction through its 5/7/12-step budget,
// issues fetch/decode strobes and the micro-op slot/phase, and takes interrupt entry
// and HALT decisions at instruction boundaries.
// Optional feature macro: SEQ_SINGLE_STEP_EN (debug hold / single-step at RUN boundaries).
module cpu_cycle_sequencer #(
    parameter int unsigned FETCH_STEPS = 2,
    parameter int unsigned INT_LENGTH  = 12,
    parameter int unsigned STEP_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [1:0]        length,
    input  logic              halt_req,
    input  logic              irq_pending,
    input  logic              int_enable,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              dbg_hold,
    input  logic              dbg_step,
`endif
    output logic              fetch_strobe,
    output logic              decode_strobe,
    output logic [STEP_W-1:0] step,
    output logic [2:0]        uop_index,
    output logic [1:0]        uop_phase,
    output logic              instr_done,
    output logic              int_active,
    output logic              halted,
    output logic              illegal_len
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StIntEntry = 2'd1,
        StHalt     = 2'd2
    } state_e;

    localparam logic [1:0] PhaseNone     = 2'd0;
    localparam logic [1:0] PhaseRegFetch = 2'd1;
    localparam logic [1:0] PhaseRegWrite = 2'd2;

    localparam logic [STEP_W-1:0] IntLast    = STEP_W'(INT_LENGTH - 1);
    localparam logic [STEP_W-1:0] FetchSteps = STEP_W'(FETCH_STEPS);
    localparam logic [STEP_W-1:0] DecodeStep = STEP_W'(1);
    localparam logic [STEP_W-1:0] Last5      = STEP_W'(4);
    localparam logic [STEP_W-1:0] Last7      = STEP_W'(6);
    localparam logic [STEP_W-1:0] Last12     = STEP_W'(11);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] len_q, len_d;      // last step index (N-1) of the current instruction
    logic              halt_q, halt_d;    // HALT/SLP latched at decode
    logic              illegal_q, illegal_d;
    logic              stall_q, stall_d;  // parked at step 0 awaiting a debug release

    logic [STEP_W-1:0] last_step;
    logic [STEP_W-1:0] k_step;
    logic              at_last;
    logic              hold_boundary;

    always_comb begin
        last_step = (state_q == StIntEntry) ? IntLast : len_q;
    end

    always_comb begin
        at_last = (state_q != StHalt) && !stall_q && (step_q == last_step);
    end

`ifdef SEQ_SINGLE_STEP_EN
    always_comb begin
        hold_boundary = dbg_hold;
    end
`else
    always_comb begin
        hold_boundary = 1'b0;
    end
`endif

    // State register; synchronous reset beats every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StRun;
            step_q    <= '0;
            len_q     <= Last5;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            len_q     <= len_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
            stall_q   <= stall_d;
        end
    end

    // Next-state: advance only on clk_en, take boundary decisions on the last step.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        len_d     = len_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        stall_d   = stall_q;
        if (clk_en) begin
            unique case (state_q)
                StRun: begin
                    if (stall_q) begin
`ifdef SEQ_SINGLE_STEP_EN
                        if (dbg_step || !dbg_hold) begin
                            stall_d = 1'b0;
                        end
`else
                        stall_d = 1'b0;
`endif
                    end else if (at_last) begin
                        step_d = '0;
                        if (halt_q) begin
                            state_d = StHalt;
                            halt_d  = 1'b0;
                        end else if (irq_pending && int_enable) begin
                            state_d = StIntEntry;
                        end else begin
                            stall_d = hold_boundary;
                        end
                    end else begin
                        if (step_q == DecodeStep) begin
                            halt_d = halt_req;
                            unique case (length)
                                2'd0: len_d = Last5;
                                2'd1: len_d = Last7;
                                2'd2: len_d = Last12;
                                default: begin
                                    len_d     = Last5;
                                    illegal_d = 1'b1;
                                end
                            endcase
                        end
                        step_d = step_q + STEP_W'(1);
                    end
                end
                StIntEntry: begin
                    if (at_last) begin
                        state_d = StRun;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                StHalt: begin
                    step_d = '0;
                    if (irq_pending) begin
                        state_d = int_enable ? StIntEntry : StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        fetch_strobe  = (state_q == StRun) && !stall_q && (step_q == '0);
        decode_strobe = (state_q == StRun) && (step_q == DecodeStep);
        step          = step_q;
        instr_done    = at_last;
        int_active    = (state_q == StIntEntry);
        halted        = (state_q == StHalt);
        illegal_len   = illegal_q;
        k_step        = step_q - FetchSteps;
        uop_index     = 3'd0;
        uop_phase     = PhaseNone;
        if (state_q != StHalt && step_q >= FetchSteps) begin
            uop_index = 3'(k_step >> 1);
            if (k_step[0]) begin
                uop_phase = PhaseRegWrite;
            end else if (step_q != last_step) begin
                uop_phase = PhaseRegFetch;
            end
        end
    end

endmodule
